spi_slave_mem: RTL and testbench



---
 rtl/spi_slave_mem_if.sv | 22 ++
 rtl/spi_slave_mem.sv | 145 ++++++++++++++
 tb/tb_spi_slave_mem.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_mem_if.sv
// SPI pin bundle between a master and the spi_slave_mem target.
// sclk_i/cs_i/mosi_i flow master->slave, miso_o flows slave->master.
interface spi_slave_mem_if;
  logic sclk_i;
  logic cs_i;
  logic mosi_i;
  logic miso_o;

  modport master (
    output sclk_i,
    output cs_i,
    output mosi_i,
    input  miso_o
  );

  modport slave (
    input  sclk_i,
    input  cs_i,
    input  mosi_i,
    output miso_o
  );
endinterface

// File: rtl/spi_slave_mem.sv
// SPI slave (modes 0/3) with a small byte register memory.
// Ports: pclk_i/prst_i system clock and sync reset, spi slave pins,
// rx_byte_o/rx_valid_o last byte, busy_o cs active, wr_count_o writes.
module spi_slave_mem #(
  parameter int          MEM_DEPTH = 16,
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  DEV_ID    = 8'hA5
) (
  input  logic           pclk_i,
  input  logic           prst_i,
  spi_slave_mem_if.slave spi,
  output logic [7:0]     rx_byte_o,
  output logic           rx_valid_o,
  output logic           busy_o,
  output logic [7:0]     wr_count_o
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RDATA, STAT, IGN
  } state_e;

  state_e state_q, state_d;

  logic [2:0]        sclk_q;
  logic [1:0]        cs_q;
  logic [1:0]        mosi_q;
  logic              armed_q;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic [ADDR_W-1:0] ptr;
  logic              wr_q;
  logic              id_q;
  logic [7:0]        mem [MEM_DEPTH];

  logic              rise, fall, cs_hi, done;
  logic [7:0]        rx_next;
  logic [ADDR_W-1:0] addr_in;

  assign rise    = sclk_q[1] & ~sclk_q[2];
  assign fall    = ~sclk_q[1] & sclk_q[2];
  assign cs_hi   = cs_q[1];
  assign rx_next = {rx_shift[6:0], mosi_q[1]};
  assign addr_in = rx_next[ADDR_W-1:0];
  assign done    = rise & (bit_cnt == 3'd7) & ~cs_hi
                 & (state_q != IDLE);

  assign spi.miso_o = tx_shift[7];
  // armed_q blocks a transaction that was cut by reset
  // until cs has been seen high again.
  assign busy_o     = armed_q & ~cs_hi;

  always_ff @(posedge pclk_i) begin
    if (prst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (armed_q && !cs_hi) state_d = CMD;
      CMD: begin
        if (done) begin
          unique case (rx_next)
            8'h02, 8'h03: state_d = ADDR;
            8'h05, 8'h9F: state_d = STAT;
            default:      state_d = IGN;
          endcase
        end
      end
      ADDR: if (done) state_d = wr_q ? WDATA : RDATA;
      default: ;
    endcase
    if (cs_hi) state_d = IDLE;
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      sclk_q     <= 3'b111;
      cs_q       <= 2'b00;
      mosi_q     <= 2'b00;
      armed_q    <= 1'b0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      ptr        <= '0;
      wr_q       <= 1'b0;
      id_q       <= 1'b0;
      rx_byte_o  <= '0;
      rx_valid_o <= 1'b0;
      wr_count_o <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      sclk_q     <= {sclk_q[1:0], spi.sclk_i};
      cs_q       <= {cs_q[0], spi.cs_i};
      mosi_q     <= {mosi_q[0], spi.mosi_i};
      armed_q    <= armed_q | cs_q[1];
      rx_valid_o <= 1'b0;
      if (cs_hi || state_q == IDLE) begin
        bit_cnt  <= '0;
        tx_shift <= '0;
      end else begin
        if (rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= rx_next;
        end
        // first fall of a byte keeps the freshly loaded MSB
        if (fall && bit_cnt != 3'd0)
          tx_shift <= {tx_shift[6:0], 1'b0};
        if (done) begin
          rx_byte_o  <= rx_next;
          rx_valid_o <= 1'b1;
          unique case (state_q)
            CMD: begin
              wr_q <= (rx_next == 8'h02);
              id_q <= (rx_next == 8'h9F);
              if (rx_next == 8'h05) tx_shift <= wr_count_o;
              if (rx_next == 8'h9F) tx_shift <= DEV_ID;
            end
            ADDR: begin
              if (wr_q) begin
                ptr <= addr_in;
              end else begin
                tx_shift <= mem[addr_in];
                ptr      <= addr_in + ADDR_W'(1);
              end
            end
            WDATA: begin
              mem[ptr]   <= rx_next;
              ptr        <= ptr + ADDR_W'(1);
              wr_count_o <= wr_count_o + 8'd1;
            end
            RDATA: begin
              tx_shift <= mem[ptr];
              ptr      <= ptr + ADDR_W'(1);
            end
            STAT: tx_shift <= id_q ? DEV_ID : wr_count_o;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_mem.sv
// Directed scoreboard bench for spi_slave_mem, SPI mode 3,
// sclk = pclk/8; rx bytes and miso bytes checked against queues.
module tb_spi_slave_mem;

  logic       pclk = 1'b0;
  logic       prst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       busy;
  logic [7:0] wr_count;

  spi_slave_mem_if spi_if ();

  spi_slave_mem #(
    .MEM_DEPTH (16),
    .ADDR_W    (4),
    .DEV_ID    (8'hA5)
  ) dut (
    .pclk_i     (pclk),
    .prst_i     (prst),
    .spi        (spi_if),
    .rx_byte_o  (rx_byte),
    .rx_valid_o (rx_valid),
    .busy_o     (busy),
    .wr_count_o (wr_count)
  );

  always #5 pclk = ~pclk;

  int         checks = 0;
  int         passed = 0;
  logic [7:0] exp_rx [$];
  logic [7:0] exp_miso [$];
  logic [7:0] model [16];
  logic [7:0] wcnt;
  logic [7:0] pkt [6];
  logic [7:0] r;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  always @(negedge pclk) begin
    if (rx_valid === 1'b1) begin
      if (exp_rx.size() == 0)
        chk("rx_extra_pulse", exp_rx.size(), 1);
      else
        chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_rx.pop_front()});
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int nb,
                          output logic [7:0] rxd);
    rxd = '0;
    for (int k = 7; k > 7 - nb; k--) begin
      spi_if.sclk_i = 1'b0;
      spi_if.mosi_i = tx[k];
      repeat (4) @(negedge pclk);
      rxd[k] = spi_if.miso_o;
      spi_if.sclk_i = 1'b1;
      repeat (4) @(negedge pclk);
    end
  endtask

  task automatic cs_low();
    spi_if.cs_i = 1'b0;
    repeat (4) @(negedge pclk);
    chk("busy_hi", {31'd0, busy}, 1);
  endtask

  task automatic cs_high();
    spi_if.cs_i = 1'b1;
    repeat (6) @(negedge pclk);
  endtask

  task automatic post(string tag);
    chk({tag, "_rx_drained"}, exp_rx.size(), 0);
    chk({tag, "_wr_count"}, {24'd0, wr_count}, {24'd0, wcnt});
    chk({tag, "_miso_idle"}, {31'd0, spi_if.miso_o}, 0);
    chk({tag, "_busy_lo"}, {31'd0, busy}, 0);
  endtask

  // Scoreboard model: expected miso byte for each position.
  task automatic run(string tag, input int n);
    logic [7:0] cmd;
    logic [3:0] a;
    logic [7:0] m;
    logic [7:0] got;
    cmd = pkt[0];
    a   = pkt[1][3:0];
    for (int i = 0; i < n; i++) begin
      exp_rx.push_back(pkt[i]);
      m = 8'h00;
      if (i > 0) begin
        case (cmd)
          8'h03: if (i >= 2) m = model[4'(a + i - 2)];
          8'h05: m = wcnt;
          8'h9F: m = 8'hA5;
          default: m = 8'h00;
        endcase
      end
      if (cmd == 8'h02 && i >= 2) begin
        model[4'(a + i - 2)] = pkt[i];
        wcnt++;
      end
      exp_miso.push_back(m);
    end
    cs_low();
    for (int i = 0; i < n; i++) begin
      spi_bits(pkt[i], 8, got);
      chk($sformatf("%s_miso%0d", tag, i), {24'd0, got},
          {24'd0, exp_miso.pop_front()});
    end
    cs_high();
    post(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prst          = 1'b1;
    spi_if.cs_i   = 1'b1;
    spi_if.sclk_i = 1'b1;
    spi_if.mosi_i = 1'b0;
    wcnt          = 8'h00;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    repeat (3) @(negedge pclk);
    chk("rst_miso", {31'd0, spi_if.miso_o}, 0);
    chk("rst_rx_byte", {24'd0, rx_byte}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wr_count", {24'd0, wr_count}, 0);
    prst = 1'b0;
    repeat (4) @(negedge pclk);

    pkt = '{8'h02, 8'h03, 8'hDE, 8'hAD, 8'h00, 8'h00};
    run("wr1", 4);
    pkt = '{8'h03, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    run("rd1", 4);

    pkt = '{8'h02, 8'h0F, 8'h11, 8'h22, 8'h00, 8'h00};
    run("wrwrap", 4);
    pkt = '{8'h03, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00};
    run("rdwrap", 5);

    pkt = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run("stat", 3);
    pkt = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run("id", 2);

    exp_rx.push_back(8'h02);
    exp_rx.push_back(8'h05);
    cs_low();
    spi_bits(8'h02, 8, r);
    spi_bits(8'h05, 8, r);
    spi_bits(8'hFF, 4, r);
    cs_high();
    post("abort");
    pkt = '{8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    run("abort_rd", 3);

    pkt = '{8'h11, 8'h01, 8'h55, 8'h00, 8'h00, 8'h00};
    run("unk", 3);
    pkt = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    run("unk_rd", 3);

    exp_rx.push_back(8'h02);
    exp_rx.push_back(8'h01);
    cs_low();
    spi_bits(8'h02, 8, r);
    spi_bits(8'h01, 8, r);
    spi_bits(8'h77, 4, r);
    prst = 1'b1;
    repeat (2) @(negedge pclk);
    prst = 1'b0;
    wcnt = 8'h00;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    spi_bits(8'h70, 4, r);
    repeat (6) @(negedge pclk);
    chk("mrst_rx_byte", {24'd0, rx_byte}, 0);
    chk("mrst_rx_valid", {31'd0, rx_valid}, 0);
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_miso", {31'd0, spi_if.miso_o}, 0);
    chk("mrst_wr_count", {24'd0, wr_count}, 0);
    cs_high();
    post("mrst");
    pkt = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    run("mrst_rd", 3);
    pkt = '{8'h02, 8'h01, 8'h77, 8'h00, 8'h00, 8'h00};
    run("mrst_wr", 3);
    pkt = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    run("mrst_rd2", 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
